// File: rtl/mem_arb_pkg.sv
// Shared types for the main_mem port arbiter.
// FSM encoding, default widths and client index constants.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   localparam int ADDR_W_DEF  = 10;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 64;

   localparam logic CLIENT_0 = 1'b0;
   localparam logic CLIENT_1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker with lock.
// req_i/last_i/lock_valid_i/lock_owner_i -> valid_o, winner_o.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       lock_valid_i,
   input  logic       lock_owner_i,
   output logic       valid_o,
   output logic       winner_o
);

   logic [1:0] elig;

   // A held lock masks the other client out entirely.
   always_comb begin
      elig = req_i;
      if (lock_valid_i) begin
         elig = lock_owner_i ? (req_i & 2'b10)
                             : (req_i & 2'b01);
      end
   end

   assign valid_o  = |elig;
   assign winner_o = (&elig) ? ~last_i
                   : (elig[1] ? CLIENT_1 : CLIENT_0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares main_mem between I-cache (0) and D-cache (1).
// Ports: req/lock/rw/addr/wdata_x in, rdata/done/err_x out, mem_* bus, grant.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_0,
   input  logic              req_1,
   input  logic              lock_0,
   input  logic              lock_1,
   input  logic              rw_0,
   input  logic              rw_1,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic [DATA_W-1:0] wdata_1,
   output logic [DATA_W-1:0] rdata_0,
   output logic [DATA_W-1:0] rdata_1,
   output logic              done_0,
   output logic              done_1,
   output logic              err_0,
   output logic              err_1,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic              grant
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   arb_state_e        state_q;
   logic              grant_q, last_q;
   logic              lock_v_q, lock_o_q;
   logic              lock_req_q, abort_q;
   logic              idle_miss_q;
   logic [7:0]        cnt_q;
   logic              mem_req_q, mem_rw_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [1:0]        done_q, err_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic              pick_v, pick_w;
   logic              own_req;
   logic [DATA_W-1:0] rdata_d;

   rr_pick2 u_pick (
      .req_i        ({req_1, req_0}),
      .last_i       (last_q),
      .lock_valid_i (lock_v_q),
      .lock_owner_i (lock_o_q),
      .valid_o      (pick_v),
      .winner_o     (pick_w)
   );

   assign own_req = lock_o_q ? req_1 : req_0;
   // Writes return no data to the client.
   assign rdata_d = mem_rw_q ? '0 : mem_rdata;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         lock_v_q    <= 1'b0;
         lock_o_q    <= 1'b0;
         lock_req_q  <= 1'b0;
         abort_q     <= 1'b0;
         idle_miss_q <= 1'b0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= '0;
         err_q       <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (pick_v) begin
                  grant_q     <= pick_w;
                  mem_req_q   <= 1'b1;
                  mem_rw_q    <= pick_w ? rw_1 : rw_0;
                  mem_addr_q  <= pick_w ? addr_1 : addr_0;
                  mem_wdata_q <= pick_w ? wdata_1 : wdata_0;
                  lock_req_q  <= pick_w ? lock_1 : lock_0;
                  cnt_q       <= '0;
                  idle_miss_q <= 1'b0;
                  state_q     <= ST_BUSY;
               end else if (lock_v_q && !own_req) begin
                  // Owner idle two cycles in a row: drop a stuck lock.
                  if (idle_miss_q) begin
                     lock_v_q    <= 1'b0;
                     idle_miss_q <= 1'b0;
                  end else begin
                     idle_miss_q <= 1'b1;
                  end
               end else begin
                  idle_miss_q <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (mem_done) begin
                  mem_req_q       <= 1'b0;
                  abort_q         <= 1'b0;
                  done_q[grant_q] <= 1'b1;
                  if (grant_q) rdata1_q <= rdata_d;
                  else         rdata0_q <= rdata_d;
                  state_q         <= ST_RESP;
               end else if (cnt_q == TO_LAST) begin
                  mem_req_q      <= 1'b0;
                  abort_q        <= 1'b1;
                  err_q[grant_q] <= 1'b1;
                  state_q        <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_RESP: begin
               done_q      <= '0;
               err_q       <= '0;
               rdata0_q    <= '0;
               rdata1_q    <= '0;
               last_q      <= grant_q;
               lock_v_q    <= lock_req_q && !abort_q;
               lock_o_q    <= grant_q;
               idle_miss_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_rw    = mem_rw_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign grant     = grant_q;
   assign done_0    = done_q[0];
   assign done_1    = done_q[1];
   assign err_0     = err_q[0];
   assign err_1     = err_q[1];
   assign rdata_0   = rdata0_q;
   assign rdata_1   = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Transaction-level model predicts grant order and responses.
module tb_mem_port_arbiter;

   localparam int TO = 64;

   typedef struct packed {
      logic        rw;
      logic        lock;
      logic [9:0]  addr;
      logic [31:0] wdata;
   } item_t;

   typedef struct packed {
      logic        c;
      logic        rw;
      logic [9:0]  addr;
      logic [31:0] wdata;
   } mtx_t;

   typedef struct packed {
      logic        c;
      logic        err;
      logic [31:0] d;
   } rsp_t;

   logic        clock, reset_n;
   logic        req_0, req_1, lock_0, lock_1, rw_0, rw_1;
   logic [9:0]  addr_0, addr_1, mem_addr;
   logic [31:0] wdata_0, wdata_1, rdata_0, rdata_1;
   logic        done_0, done_1, err_0, err_1;
   logic        mem_req, mem_rw, mem_done, grant;
   logic [31:0] mem_wdata, mem_rdata;

   int n_chk, n_fail;
   item_t cq0[$], cq1[$];
   mtx_t  mq[$];
   rsp_t  rq[$];
   int    to_idx[$];
   int    lat;
   bit    mon_en, spur;
   logic [31:0] exp_mem [1024];
   logic [31:0] env_mem [1024];

   mem_port_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .req_0(req_0), .req_1(req_1),
      .lock_0(lock_0), .lock_1(lock_1),
      .rw_0(rw_0), .rw_1(rw_1),
      .addr_0(addr_0), .addr_1(addr_1),
      .wdata_0(wdata_0), .wdata_1(wdata_1),
      .rdata_0(rdata_0), .rdata_1(rdata_1),
      .done_0(done_0), .done_1(done_1),
      .err_0(err_0), .err_1(err_1),
      .mem_req(mem_req), .mem_rw(mem_rw),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .grant(grant)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic bit is_to(input int k);
      foreach (to_idx[i]) if (to_idx[i] == k) return 1'b1;
      return 1'b0;
   endfunction

   function automatic item_t mk(input bit rw, input bit lk,
                                input logic [9:0] a,
                                input logic [31:0] d);
      item_t it;
      it.rw = rw; it.lock = lk; it.addr = a; it.wdata = d;
      return it;
   endfunction

   task automatic init_mem(input logic [31:0] seed);
      logic [31:0] v;
      for (int a = 0; a < 1024; a++) begin
         v = (32'(a) * 32'h9E3779B1) ^ seed;
         exp_mem[a] = v;
         env_mem[a] = v;
      end
   endtask

   task automatic set_mem(input int a, input logic [31:0] v);
      exp_mem[a] = v;
      env_mem[a] = v;
   endtask

   // main_mem model: answers each new mem_req after lat cycles,
   // stays silent for transaction indices listed in to_idx.
   initial begin
      int  m_idx, m_wait;
      bit  m_prev, m_to;
      mem_done = 1'b0; mem_rdata = '0;
      m_idx = 0; m_wait = -1; m_prev = 0; m_to = 0;
      forever begin
         @(negedge clock);
         mem_done  = 1'b0;
         mem_rdata = '0;
         if (!reset_n) begin
            m_idx = 0; m_wait = -1; m_prev = 0;
         end else begin
            if (spur && !mem_req) begin
               mem_done  = 1'b1;
               mem_rdata = 32'h5555AAAA;
               spur      = 1'b0;
            end
            if (mem_req && !m_prev) begin
               m_to   = is_to(m_idx);
               m_idx++;
               m_wait = (lat < 0) ? int'($urandom_range(0, 4)) : lat;
            end
            if (m_wait == 0 && mem_req && !m_to) begin
               mem_done = 1'b1;
               if (mem_rw) begin
                  env_mem[mem_addr] = mem_wdata;
                  mem_rdata = $urandom;
               end else begin
                  mem_rdata = env_mem[mem_addr];
               end
               m_wait = -1;
            end else if (m_wait > 0) begin
               m_wait--;
            end
            m_prev = mem_req;
         end
      end
   end

   // Monitor: checks the mem bus at each new transaction and the
   // client outputs at each done/err pulse against the queues.
   initial begin
      bit          prev;
      int          busy_n;
      logic [9:0]  cur_a;
      mtx_t        m;
      rsp_t        r;
      prev = 0; busy_n = 0; cur_a = '0;
      forever begin
         @(negedge clock);
         if (!reset_n || !mon_en) begin
            prev = 0; busy_n = 0;
         end else begin
            if (mem_req && !prev) begin
               busy_n = 0;
               if (mq.size() == 0) begin
                  chk("mem_req_unexpected", 64'(mem_req), 0);
               end else begin
                  m = mq.pop_front();
                  chk("grant", 64'(grant), 64'(m.c));
                  chk("mem_rw", 64'(mem_rw), 64'(m.rw));
                  chk("mem_addr", 64'(mem_addr), 64'(m.addr));
                  chk("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
                  cur_a = m.addr;
               end
            end
            if (mem_req) begin
               busy_n++;
               chk("mem_addr_stable", 64'(mem_addr), 64'(cur_a));
            end
            if (done_0 | err_0 | done_1 | err_1) begin
               if (rq.size() == 0) begin
                  chk("pulse_unexpected",
                      64'({err_1, done_1, err_0, done_0}), 0);
               end else begin
                  r = rq.pop_front();
                  chk("resp_done", 64'({done_1, done_0}),
                      r.err ? 64'd0 : (64'd1 << r.c));
                  chk("resp_err", 64'({err_1, err_0}),
                      r.err ? (64'd1 << r.c) : 64'd0);
                  chk("rdata_0", 64'(rdata_0), r.c ? 64'd0 : 64'(r.d));
                  chk("rdata_1", 64'(rdata_1), r.c ? 64'(r.d) : 64'd0);
                  chk("mem_req_in_resp", 64'(mem_req), 0);
                  if (r.err) chk("timeout_len", 64'(busy_n), 64'(TO));
                  else if (lat >= 0)
                     chk("done_latency", 64'(busy_n), 64'(lat + 1));
               end
            end else begin
               chk("rdata_idle", {rdata_1, rdata_0}, 0);
            end
            prev = mem_req;
         end
      end
   end

   // Reference model: serve order from round-robin and lock rules.
   task automatic build_expect(input int dly0);
      int    p0, p1, k;
      bit    last, lk_v, lk_o, g, pend0, pend1, to;
      item_t it;
      mtx_t  m;
      rsp_t  r;
      p0 = 0; p1 = 0; k = 0;
      last = 1; lk_v = 0; lk_o = 0;
      while (p0 < cq0.size() || p1 < cq1.size()) begin
         pend0 = (p0 < cq0.size()) && !(k == 0 && dly0 > 0);
         pend1 = p1 < cq1.size();
         if (lk_v && (lk_o ? pend1 : pend0)) g = lk_o;
         else if (pend0 && pend1)            g = !last;
         else                                g = !pend0;
         if (g) begin it = cq1[p1]; p1++; end
         else   begin it = cq0[p0]; p0++; end
         to = is_to(k);
         m.c = g; m.rw = it.rw; m.addr = it.addr; m.wdata = it.wdata;
         mq.push_back(m);
         r.c = g; r.err = to; r.d = '0;
         if (!to) begin
            if (it.rw) exp_mem[it.addr] = it.wdata;
            else       r.d = exp_mem[it.addr];
         end
         rq.push_back(r);
         last = g;
         lk_v = it.lock && !to;
         lk_o = g;
         k++;
      end
   endtask

   task automatic load0(input int i, input bit en);
      if (en && i < cq0.size()) begin
         req_0 = 1; lock_0 = cq0[i].lock; rw_0 = cq0[i].rw;
         addr_0 = cq0[i].addr; wdata_0 = cq0[i].wdata;
      end else begin
         req_0 = 0; lock_0 = 0;
      end
   endtask

   task automatic load1(input int i);
      if (i < cq1.size()) begin
         req_1 = 1; lock_1 = cq1[i].lock; rw_1 = cq1[i].rw;
         addr_1 = cq1[i].addr; wdata_1 = cq1[i].wdata;
      end else begin
         req_1 = 0; lock_1 = 0;
      end
   endtask

   // Clients hold req until their pulse, then renew or drop it.
   task automatic run_clients(input int dly0);
      int i0, i1, cyc;
      bit a0, a1, s0;
      i0 = 0; i1 = 0; s0 = (dly0 == 0);
      load0(i0, s0); load1(i1);
      for (cyc = 0; cyc < 20000; cyc++) begin
         if (i0 >= cq0.size() && i1 >= cq1.size()) break;
         @(negedge clock);
         a0 = done_0 | err_0;
         a1 = done_1 | err_1;
         @(posedge clock); #1;
         if (a0) i0++;
         if (a1) i1++;
         if (!s0 && cyc + 1 >= dly0) s0 = 1;
         load0(i0, s0); load1(i1);
      end
      chk("clients_served", 64'(i0 + i1), 64'(cq0.size() + cq1.size()));
   endtask

   task automatic run_phase(input int dly0);
      build_expect(dly0);
      run_clients(dly0);
      repeat (3) @(negedge clock);
      chk("sb_mem_left", 64'(mq.size()), 0);
      chk("sb_resp_left", 64'(rq.size()), 0);
      cq0.delete(); cq1.delete(); to_idx.delete();
      mq.delete(); rq.delete();
   endtask

   task automatic apply_reset;
      req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0;
      rw_0 = 0; rw_1 = 0; addr_0 = '0; addr_1 = '0;
      wdata_0 = '0; wdata_1 = '0;
      reset_n = 0;
      repeat (2) @(negedge clock);
      chk("rst_ctrl", 64'({mem_req, mem_rw, grant, done_0,
                           done_1, err_0, err_1}), 0);
      chk("rst_bus", 64'({mem_addr, mem_wdata}), 0);
      chk("rst_rdata", {rdata_1, rdata_0}, 0);
      reset_n = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      int n0, n1;
      n_chk = 0; n_fail = 0; mon_en = 1; spur = 0;
      reset_n = 0;

      // Single read
      lat = 2;
      init_mem(32'h1234_0001);
      set_mem(4, 32'hDEADBEEF);
      cq0.push_back(mk(0, 0, 10'h004, '0));
      apply_reset;
      run_phase(0);

      // Tie from reset: 0,1,0,1,...
      lat = -1;
      for (int i = 0; i < 3; i++) begin
         cq0.push_back(mk($urandom % 2, 0, 10'($urandom % 32), $urandom));
         cq1.push_back(mk($urandom % 2, 0, 10'($urandom % 32), $urandom));
      end
      apply_reset;
      run_phase(0);

      // Locked write-back + refill for client 1
      lat = 1;
      cq1.push_back(mk(1, 1, 10'h3A0, 32'hCAFE_0001));
      cq1.push_back(mk(0, 0, 10'h120, '0));
      cq0.push_back(mk(0, 0, 10'h050, '0));
      apply_reset;
      run_phase(2);

      // Timeout then normal transfer
      cq0.push_back(mk(0, 0, 10'h010, '0));
      cq1.push_back(mk(0, 0, 10'h020, '0));
      to_idx.push_back(0);
      apply_reset;
      run_phase(0);

      // Reset in the middle of BUSY
      apply_reset;
      mon_en = 0;
      to_idx.push_back(0);
      req_0 = 1; rw_0 = 0; addr_0 = 10'h033;
      got = 0;
      for (int w = 0; w < 10 && !got; w++) begin
         @(negedge clock);
         got = mem_req;
      end
      chk("busy_mem_req", 64'(mem_req), 1);
      @(negedge clock);
      reset_n = 0;
      #1;
      chk("async_mem_req_drop", 64'(mem_req), 0);
      req_0 = 0;
      repeat (2) begin
         @(negedge clock);
         chk("no_pulse_in_reset", 64'({err_1, done_1, err_0, done_0}), 0);
      end
      reset_n = 1;
      to_idx.delete();
      mon_en = 1;
      cq1.push_back(mk(0, 0, 10'h044, '0));
      run_phase(0);

      // Spurious mem_done in IDLE
      apply_reset;
      spur = 1;
      repeat (4) begin
         @(negedge clock);
         chk("spur_mem_req", 64'(mem_req), 0);
         chk("spur_pulse", 64'({err_1, done_1, err_0, done_0}), 0);
      end
      cq0.push_back(mk(0, 0, 10'h007, '0));
      run_phase(0);

      // Randomized mixes with locks and occasional timeouts
      for (int rnd = 0; rnd < 8; rnd++) begin
         lat = (rnd % 3 == 0) ? int'($urandom_range(0, 3)) : -1;
         init_mem($urandom);
         n0 = $urandom_range(0, 10);
         n1 = $urandom_range(0, 10);
         if (n0 + n1 == 0) n1 = 1;
         for (int i = 0; i < n0; i++)
            cq0.push_back(mk($urandom % 2, ($urandom % 4) == 0,
                             10'($urandom % 64), $urandom));
         for (int i = 0; i < n1; i++)
            cq1.push_back(mk($urandom % 2, ($urandom % 3) == 0,
                             10'($urandom % 64), $urandom));
         for (int k = 0; k < n0 + n1; k++)
            if ($urandom % 12 == 0) to_idx.push_back(k);
         apply_reset;
         run_phase(0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
